// File: rtl/harris_pkg.sv
// rtl/harris_pkg.sv - shared widths, window geometry and frame state encoding for the Harris frame controller
package harris_pkg;

    localparam int FEATURE_W = 54;
    localparam int SCALE_W   = 8;
    localparam int X_W       = 10;
    localparam int Y_W       = 9;
    localparam int WIN       = 7;
    localparam int HALF_WIN  = 3;
    localparam int COUNT_W   = 16;
    localparam int TAG_W     = 1 + X_W + Y_W;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/harris_tag_pipe.sv
// rtl/harris_tag_pipe.sv - fixed-depth delay line carrying {valid, cx, cy} window tags alongside the detector pipeline
module harris_tag_pipe #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_tag,
    output logic [WIDTH-1:0] o_tag
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    // Shifts every clock so tag timing follows wall-clock latency, not accepts
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_tag;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_tag = r_stage[DEPTH-1];

endmodule

// File: rtl/harris_frame_ctrl.sv
// rtl/harris_frame_ctrl.sv - frame sequencer: pixel accept, detector clock enable, window tagging, corner thresholding and per-frame count
module harris_frame_ctrl
    import harris_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int PIPE_LAT = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        pix_valid,
    output logic                        pix_ready,
    input  logic                        sof,
    input  logic [SCALE_W-1:0]          scale_in,
    input  logic signed [FEATURE_W-1:0] threshold,
    input  logic signed [FEATURE_W-1:0] harris_feature,
    output logic                        det_clk_en,
    output logic [SCALE_W-1:0]          det_scale,
    output logic                        corner_valid,
    output logic [X_W-1:0]              corner_x,
    output logic [Y_W-1:0]              corner_y,
    output logic                        frame_done,
    output logic [COUNT_W-1:0]          corner_count
);

    localparam logic [X_W-1:0] X_LAST     = X_W'(H_ACTIVE - 1);
    localparam logic [Y_W-1:0] Y_LAST     = Y_W'(V_ACTIVE - 1);
    localparam logic [3:0]     DRAIN_LAST = 4'(PIPE_LAT - 1);
    localparam logic [X_W-1:0] X_WIN_MIN  = X_W'(WIN - 1);
    localparam logic [Y_W-1:0] Y_WIN_MIN  = Y_W'(WIN - 1);

    state_t               r_state;
    logic [X_W-1:0]       r_col;
    logic [Y_W-1:0]       r_row;
    logic [3:0]           r_drain_cnt;
    logic [COUNT_W-1:0]   r_count;
    logic [SCALE_W-1:0]   r_det_scale;
    logic                 r_corner_valid;
    logic [X_W-1:0]       r_corner_x;
    logic [Y_W-1:0]       r_corner_y;
    logic                 r_frame_done;
    logic [COUNT_W-1:0]   r_corner_count;

    logic                 w_ready;
    logic                 w_restart;
    logic                 w_accept;
    logic [X_W-1:0]       w_px;
    logic [Y_W-1:0]       w_py;
    logic                 w_win_ok;
    logic [TAG_W-1:0]     w_tag_in;
    logic [TAG_W-1:0]     w_tag_out;
    logic                 w_tag_valid;
    logic [X_W-1:0]       w_tag_x;
    logic [Y_W-1:0]       w_tag_y;
    logic                 w_hit;
    logic [COUNT_W-1:0]   w_count_nxt;

    assign w_ready    = (r_state == IDLE) || (r_state == ACTIVE);
    assign w_restart  = pix_valid && w_ready && sof;
    // In IDLE only a start-of-frame pixel counts as accepted
    assign w_accept   = pix_valid && ((r_state == ACTIVE) || ((r_state == IDLE) && sof));
    assign pix_ready  = w_ready;
    assign det_clk_en = w_accept;

    assign w_px     = w_restart ? '0 : r_col;
    assign w_py     = w_restart ? '0 : r_row;
    assign w_win_ok = (w_px >= X_WIN_MIN) && (w_py >= Y_WIN_MIN);
    assign w_tag_in = {w_win_ok && w_accept,
                       w_px - X_W'(HALF_WIN),
                       w_py - Y_W'(HALF_WIN)};

    harris_tag_pipe #(
        .DEPTH (PIPE_LAT),
        .WIDTH (TAG_W)
    ) u_tag_pipe (
        .clk   (clk),
        .reset (reset),
        .i_tag (w_tag_in),
        .o_tag (w_tag_out)
    );

    assign w_tag_valid = w_tag_out[TAG_W-1];
    assign w_tag_x     = w_tag_out[TAG_W-2 -: X_W];
    assign w_tag_y     = w_tag_out[Y_W-1:0];
    assign w_hit       = w_tag_valid && (harris_feature > threshold);
    assign w_count_nxt = (w_hit && (r_count != {COUNT_W{1'b1}})) ? r_count + 1'b1 : r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= IDLE;
            r_col          <= '0;
            r_row          <= '0;
            r_drain_cnt    <= '0;
            r_count        <= '0;
            r_det_scale    <= '0;
            r_corner_valid <= 1'b0;
            r_corner_x     <= '0;
            r_corner_y     <= '0;
            r_frame_done   <= 1'b0;
            r_corner_count <= '0;
        end else begin
            r_frame_done   <= 1'b0;
            r_corner_valid <= w_hit;
            if (w_hit) begin
                r_corner_x <= w_tag_x;
                r_corner_y <= w_tag_y;
            end
            r_count <= w_restart ? '0 : w_count_nxt;
            if (w_restart) begin
                r_det_scale <= scale_in;
            end

            case (r_state)
                IDLE: begin
                    if (w_restart) begin
                        r_col   <= X_W'(1);
                        r_row   <= '0;
                        r_state <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (w_restart) begin
                        r_col <= X_W'(1);
                        r_row <= '0;
                    end else if (pix_valid) begin
                        if (r_col == X_LAST) begin
                            r_col <= '0;
                            if (r_row == Y_LAST) begin
                                r_row       <= '0;
                                r_drain_cnt <= '0;
                                r_state     <= DRAIN;
                            end else begin
                                r_row <= r_row + 1'b1;
                            end
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (r_drain_cnt == DRAIN_LAST) begin
                        r_frame_done <= 1'b1;
                        r_state      <= DONE;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 1'b1;
                    end
                end
                DONE: begin
                    r_corner_count <= w_count_nxt;
                    r_state        <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign det_scale    = r_det_scale;
    assign corner_valid = r_corner_valid;
    assign corner_x     = r_corner_x;
    assign corner_y     = r_corner_y;
    assign frame_done   = r_frame_done;
    assign corner_count = r_corner_count;

endmodule
